// File: rtl/kbd_pkg.sv
// Shared types and constants for the keyboard event FIFO: entry layout, prefix
// decoder states, PS/2 prefix bytes and the CPU window decode.
package kbd_pkg;

    localparam int          KBD_DEPTH   = 8;
    localparam logic [7:0]  PS2_EXT     = 8'hE0;
    localparam logic [7:0]  PS2_REL     = 8'hF0;
    localparam logic [2:0]  KBD_WIN_SEL = 3'b011;

    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } kbd_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_REL,
        ST_EXT_REL
    } kbd_state_t;

    // The status register only has three bits for the occupancy.
    function automatic logic [2:0] sat_count(input int n);
        return (n > 7) ? 3'd7 : 3'(n);
    endfunction

endpackage

// File: rtl/kbd_event_fifo_if.sv
// Receiver-side event inputs and the CPU-side address/interrupt signals of the
// keyboard event FIFO.
interface kbd_event_fifo_if;
    logic [7:0]  in_code;
    logic        in_valid;
    logic        in_error;
    logic [15:0] sys_adr;
    logic        sys_irq;

    modport master (output in_code, in_valid, in_error, sys_adr, input sys_irq);
    modport slave  (input in_code, in_valid, in_error, sys_adr, output sys_irq);
endinterface

// File: rtl/kbd_fifo.sv
// Generic synchronous FIFO. DEPTH must be a power of two so the pointers wrap
// on their own; a pop on an empty FIFO is ignored, a push when full is only
// accepted together with a pop.
module kbd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 10
) (
    input  logic                   sys_clk,
    input  logic                   RESB,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       wdata_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge sys_clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    always_ff @(posedge sys_clk or negedge RESB) begin
        if (!RESB) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= AW'(wr_ptr_q + 1);
            if (do_pop)  rd_ptr_q <= AW'(rd_ptr_q + 1);
            case ({do_push, do_pop})
                2'b10:   count_q <= (AW+1)'(count_q + 1);
                2'b01:   count_q <= (AW+1)'(count_q - 1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/kbd_event_fifo.sv
// Keyboard event FIFO: PS/2 prefix decoder feeding an event queue read through
// a CPU window. Define KBD_IRQ_EN to build the active-low interrupt output.
module kbd_event_fifo
    import kbd_pkg::*;
#(
    parameter int DEPTH = KBD_DEPTH
) (
    input  logic            sys_clk,
    input  logic            RESB,
    kbd_event_fifo_if.slave bus,
    output wire  [7:0]      sys_data
);
    // state      | meaning
    // ST_IDLE    | no prefix pending
    // ST_EXT     | E0 seen
    // ST_REL     | F0 seen
    // ST_EXT_REL | E0 then F0 seen
    kbd_state_t state_q;
    kbd_entry_t entry_q, head;
    logic       push_q;
    logic       full, empty, pop, clr, sel, access, is_pfx;
    logic       ovf_q, err_q, adr_vld_q, rd_en_q;
    logic [15:0] adr_q;
    logic [7:0]  rd_data_q, status;
    logic [$clog2(DEPTH):0] count;

    assign is_pfx = (bus.in_code == PS2_EXT) || (bus.in_code == PS2_REL);

    always_ff @(posedge sys_clk or negedge RESB) begin
        if (!RESB) begin
            state_q <= ST_IDLE;
            push_q  <= 1'b0;
            entry_q <= '0;
        end else begin
            push_q <= 1'b0;
            if (bus.in_valid) begin
                entry_q.code <= bus.in_code;
                if (bus.in_error) begin
                    state_q <= ST_IDLE;
                end else begin
                    case (state_q)
                        ST_IDLE: begin
                            if (bus.in_code == PS2_EXT)      state_q <= ST_EXT;
                            else if (bus.in_code == PS2_REL) state_q <= ST_REL;
                            else begin
                                push_q      <= 1'b1;
                                entry_q.ext <= 1'b0;
                                entry_q.rel <= 1'b0;
                            end
                        end
                        ST_EXT: begin
                            if (bus.in_code == PS2_REL) state_q <= ST_EXT_REL;
                            else if (bus.in_code != PS2_EXT) begin
                                state_q     <= ST_IDLE;
                                push_q      <= 1'b1;
                                entry_q.ext <= 1'b1;
                                entry_q.rel <= 1'b0;
                            end
                        end
                        default: begin
                            // A second prefix after F0 is malformed: drop the sequence.
                            state_q <= ST_IDLE;
                            if (!is_pfx) begin
                                push_q      <= 1'b1;
                                entry_q.ext <= (state_q == ST_EXT_REL);
                                entry_q.rel <= 1'b1;
                            end
                        end
                    endcase
                end
            end
        end
    end

    kbd_fifo #(.DEPTH(DEPTH), .WIDTH($bits(kbd_entry_t))) u_fifo (
        .sys_clk (sys_clk),
        .RESB    (RESB),
        .push_i  (push_q),
        .pop_i   (pop),
        .wdata_i (entry_q),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    // Side effects fire once per new address, not per cycle the address is held.
    assign sel    = (bus.sys_adr[15:13] == KBD_WIN_SEL);
    assign access = sel && (!adr_vld_q || (bus.sys_adr != adr_q));
    assign pop    = access && bus.sys_adr[0] && !empty;
    assign clr    = access && !bus.sys_adr[0];
    assign status = {!empty, ovf_q, err_q, head.rel && !empty, head.ext && !empty,
                     sat_count(int'(count))};

    always_ff @(posedge sys_clk or negedge RESB) begin
        if (!RESB) begin
            adr_q     <= '0;
            adr_vld_q <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_data_q <= '0;
            ovf_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            adr_q     <= bus.sys_adr;
            adr_vld_q <= sel;
            rd_en_q   <= sel;
            if (access) rd_data_q <= bus.sys_adr[0] ? (empty ? 8'h00 : head.code) : status;
            ovf_q <= (ovf_q && !clr) || (push_q && full && !pop);
            err_q <= (err_q && !clr) || (bus.in_valid && bus.in_error);
        end
    end

    assign sys_data = rd_en_q ? rd_data_q : 8'hZZ;

`ifdef KBD_IRQ_EN
    logic irq_q;
    always_ff @(posedge sys_clk or negedge RESB) begin
        if (!RESB) irq_q <= 1'b1;
        else       irq_q <= empty && !ovf_q;
    end
    assign bus.sys_irq = irq_q;
`else
    assign bus.sys_irq = 1'b1;
`endif
endmodule

// File: tb/tb_kbd_event_fifo.sv
// Bench for kbd_event_fifo: directed scenarios plus a randomized run checked
// against a queue-based model of the event stream.
module tb_kbd_event_fifo;
    localparam int DEPTH = 8;

    logic sys_clk = 1'b0;
    logic RESB    = 1'b0;
    wire [7:0] sys_data;

    kbd_event_fifo_if bus ();

    kbd_event_fifo #(.DEPTH(DEPTH)) dut (
        .sys_clk  (sys_clk),
        .RESB     (RESB),
        .bus      (bus),
        .sys_data (sys_data)
    );

    always #5 sys_clk = ~sys_clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: queue of {ext, rel, code} plus pending-prefix flags.
    logic [9:0] mq[$];
    bit m_ext, m_rel, m_ovf, m_err;

    function automatic logic [7:0] m_status();
        int c = mq.size();
        logic [9:0] h = (c != 0) ? mq[0] : 10'h000;
        return {c != 0, m_ovf, m_err, h[8], h[9], (c > 7) ? 3'd7 : c[2:0]};
    endfunction

    function automatic logic m_irq();
`ifdef KBD_IRQ_EN
        return (mq.size() != 0 || m_ovf) ? 1'b0 : 1'b1;
`else
        return 1'b1;
`endif
    endfunction

    function automatic void m_byte(input logic [7:0] b, input bit e);
        if (e) begin
            m_err = 1; m_ext = 0; m_rel = 0;
        end else if (b == 8'hE0 || b == 8'hF0) begin
            if (m_rel) begin m_ext = 0; m_rel = 0; end
            else if (b == 8'hE0) m_ext = 1;
            else m_rel = 1;
        end else begin
            if (mq.size() >= DEPTH) m_ovf = 1;
            else mq.push_back({m_ext, m_rel, b});
            m_ext = 0; m_rel = 0;
        end
    endfunction

    task automatic do_reset();
        @(negedge sys_clk);
        RESB = 1'b0;
        bus.in_valid = 1'b0; bus.in_error = 1'b0; bus.in_code = 8'h00; bus.sys_adr = 16'h0000;
        repeat (2) @(negedge sys_clk);
        RESB = 1'b1;
        mq.delete(); m_ext = 0; m_rel = 0; m_ovf = 0; m_err = 0;
    endtask

    task automatic send(input logic [7:0] b, input bit e);
        @(negedge sys_clk);
        bus.in_code = b; bus.in_valid = 1'b1; bus.in_error = e;
        @(negedge sys_clk);
        bus.in_valid = 1'b0; bus.in_error = 1'b0;
        m_byte(b, e);
    endtask

    task automatic do_read(input logic [15:0] adr, output logic [7:0] d);
        @(negedge sys_clk);
        bus.sys_adr = adr;
        @(negedge sys_clk);
        d = sys_data;
        bus.sys_adr = 16'h0000;
    endtask

    task automatic rd_status(output logic [7:0] d);
        do_read(16'h6000, d);
        m_ovf = 0; m_err = 0;
    endtask

    task automatic rd_data(output logic [7:0] d);
        do_read(16'h6001, d);
        if (mq.size() != 0) void'(mq.pop_front());
    endtask

    task automatic test_reset();
        logic [7:0] d;
        do_reset();
        n_vec++; if (bus.sys_irq !== 1'b1) begin n_err++; $display("FAIL reset_irq: got %b want 1", bus.sys_irq); end
        rd_status(d);
        n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL reset_status: got %02h want 00", d); end
        rd_data(d);
        n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL reset_data: got %02h want 00", d); end
    endtask

    task automatic test_single();
        logic [7:0] d;
        do_reset();
        send(8'h1C, 0);
        rd_status(d);
        n_vec++; if (d !== 8'h81) begin n_err++; $display("FAIL single_status: got %02h want 81", d); end
        rd_data(d);
        n_vec++; if (d !== 8'h1C) begin n_err++; $display("FAIL single_data: got %02h want 1c", d); end
        rd_status(d);
        n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL single_status2: got %02h want 00", d); end
    endtask

    task automatic test_prefix();
        logic [7:0] d;
        logic [7:0] seq [7] = '{8'hE0, 8'hF0, 8'h74, 8'hE0, 8'h1C, 8'hF0, 8'h2A};
        logic [7:0] exp_st [3] = '{8'h99, 8'h89, 8'h91};
        logic [7:0] exp_cd [3] = '{8'h74, 8'h1C, 8'h2A};
        do_reset();
        send(seq[0], 0); send(seq[1], 0); send(seq[2], 0);
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin send(seq[3], 0); send(seq[4], 0); end
            if (k == 2) begin send(seq[5], 0); send(seq[6], 0); end
            rd_status(d);
            n_vec++; if (d !== exp_st[k]) begin n_err++; $display("FAIL prefix_status%0d: got %02h want %02h", k, d, exp_st[k]); end
            rd_data(d);
            n_vec++; if (d !== exp_cd[k]) begin n_err++; $display("FAIL prefix_data%0d: got %02h want %02h", k, d, exp_cd[k]); end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] d;
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            @(negedge sys_clk);
            bus.in_code = 8'(i); bus.in_valid = 1'b1; bus.in_error = 1'b0;
            m_byte(8'(i), 0);
        end
        @(negedge sys_clk);
        bus.in_valid = 1'b0;
        rd_status(d);
        n_vec++; if (d !== 8'hC7) begin n_err++; $display("FAIL ovf_status: got %02h want c7", d); end
        rd_status(d);
        n_vec++; if (d !== 8'h87) begin n_err++; $display("FAIL ovf_cleared: got %02h want 87", d); end
        for (int i = 1; i <= 8; i++) begin
            rd_data(d);
            n_vec++; if (d !== 8'(i)) begin n_err++; $display("FAIL ovf_pop%0d: got %02h want %02h", i, d, 8'(i)); end
        end
        rd_status(d);
        n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL ovf_drained: got %02h want 00", d); end
    endtask

    task automatic test_error();
        logic [7:0] d;
        do_reset();
        send(8'hF0, 1);
        send(8'h1C, 0);
        rd_status(d);
        n_vec++; if (d !== 8'hA1) begin n_err++; $display("FAIL err_status: got %02h want a1", d); end
        rd_data(d);
        n_vec++; if (d !== 8'h1C) begin n_err++; $display("FAIL err_data: got %02h want 1c", d); end
        rd_status(d);
        n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL err_cleared: got %02h want 00", d); end
    endtask

    task automatic test_hold();
        logic [7:0] d;
        do_reset();
        send(8'h11, 0);
        send(8'h22, 0);
        @(negedge sys_clk);
        bus.sys_adr = 16'h6001;
        repeat (3) @(negedge sys_clk);
        d = sys_data;
        bus.sys_adr = 16'h0000;
        void'(mq.pop_front());
        n_vec++; if (d !== 8'h11) begin n_err++; $display("FAIL hold_data: got %02h want 11", d); end
        rd_status(d);
        n_vec++; if (d !== 8'h81) begin n_err++; $display("FAIL hold_count: got %02h want 81", d); end
        rd_data(d);
        n_vec++; if (d !== 8'h22) begin n_err++; $display("FAIL hold_next: got %02h want 22", d); end
    endtask

    task automatic test_reset_mid_prefix();
        logic [7:0] d;
        do_reset();
        send(8'hE0, 0);
        do_reset();
        send(8'h1C, 0);
        rd_status(d);
        n_vec++; if (d !== 8'h81) begin n_err++; $display("FAIL midrst_status: got %02h want 81", d); end
        rd_data(d);
        n_vec++; if (d !== 8'h1C) begin n_err++; $display("FAIL midrst_data: got %02h want 1c", d); end
    endtask

    task automatic test_irq();
        logic [7:0] d;
        logic exp_lo;
`ifdef KBD_IRQ_EN
        exp_lo = 1'b0;
`else
        exp_lo = 1'b1;
`endif
        do_reset();
        send(8'h1C, 0);
        repeat (2) @(negedge sys_clk);
        n_vec++; if (bus.sys_irq !== exp_lo) begin n_err++; $display("FAIL irq_pending: got %b want %b", bus.sys_irq, exp_lo); end
        rd_data(d);
        repeat (2) @(negedge sys_clk);
        n_vec++; if (bus.sys_irq !== 1'b1) begin n_err++; $display("FAIL irq_drained: got %b want 1", bus.sys_irq); end
    endtask

    task automatic test_random();
        logic [7:0] d, exp, b;
        logic [15:0] adr;
        int op;
        do_reset();
        for (int it = 0; it < 600; it++) begin
            op = $urandom_range(0, 9);
            if (op <= 4) begin
                case ($urandom_range(0, 5))
                    0: b = 8'hE0;
                    1: b = 8'hF0;
                    default: b = 8'($urandom);
                endcase
                send(b, $urandom_range(0, 11) == 0);
            end else if (op <= 6) begin
                exp = m_status();
                adr = 16'h6000 | (16'($urandom) & 16'h1FFE);
                do_read(adr, d);
                m_ovf = 0; m_err = 0;
                n_vec++; if (d !== exp) begin n_err++; $display("FAIL rnd_status it%0d: got %02h want %02h", it, d, exp); end
            end else if (op <= 8) begin
                exp = (mq.size() != 0) ? mq[0][7:0] : 8'h00;
                adr = 16'h6001 | (16'($urandom) & 16'h1FFE);
                do_read(adr, d);
                if (mq.size() != 0) void'(mq.pop_front());
                n_vec++; if (d !== exp) begin n_err++; $display("FAIL rnd_data it%0d: got %02h want %02h", it, d, exp); end
            end else begin
                @(negedge sys_clk);
                bus.sys_adr = ($urandom_range(0, 1) != 0) ? 16'h8001 : 16'h4000;
                @(negedge sys_clk);
                bus.sys_adr = 16'h0000;
                repeat (2) @(negedge sys_clk);
                n_vec++; if (bus.sys_irq !== m_irq()) begin n_err++; $display("FAIL rnd_irq it%0d: got %b want %b", it, bus.sys_irq, m_irq()); end
            end
        end
    endtask

    initial begin
        bus.in_code = 8'h00; bus.in_valid = 1'b0; bus.in_error = 1'b0; bus.sys_adr = 16'h0000;
        test_reset();
        test_single();
        test_prefix();
        test_overflow();
        test_error();
        test_hold();
        test_reset_mid_prefix();
        test_irq();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/kbd_event_fifo.md
KBD_EVENT_FIFO -- requirements
Module: kbd_event_fifo

Interface
REQ-001 DEPTH, 8, FIFO entries; power of two, 2..16.
REQ-002 sys_clk  input  1  single clock; all state SHALL be on its rising edge.
REQ-003 RESB  input  1  asynchronous active-low reset.
REQ-004 in_code  input  8  received PS/2 byte from the upstream receiver, already in sys_clk domain.
REQ-005 in_valid  input  1  one-cycle strobe qualifying in_code.
REQ-006 in_error  input  1  frame error flag, sampled with in_valid.
REQ-007 sys_adr  input  16  CPU address; block selected when sys_adr[15:13]==3'b011 (0x6000-0x7FFF); register select = sys_adr[0].
REQ-008 sys_data  output  8  registered read data; high-Z when not selected.
REQ-009 sys_irq  output  1  active-low interrupt request.

Function
REQ-010 Prefix FSM states: IDLE, EXT (E0 seen), REL (F0 seen), EXT_REL (E0 then F0); each transition occurs only on a cycle with in_valid=1.
REQ-011 IDLE: E0->EXT, F0->REL, other->push {ext=0,rel=0,code}, stay IDLE.
REQ-012 EXT: F0->EXT_REL, E0->stay EXT, other->push {ext=1,rel=0,code}, ->IDLE.
REQ-013 REL: other (not E0/F0)->push {ext=0,rel=1,code}, ->IDLE; E0 or F0->IDLE, no push.
REQ-014 EXT_REL: other->push {ext=1,rel=1,code}, ->IDLE; E0 or F0->IDLE, no push.
REQ-015 in_valid with in_error=1 SHALL push nothing, set sticky err, and force IDLE.
REQ-016 Entry = 10 bits {ext, rel, code}; push written one cycle after in_valid.
REQ-017 Push when full SHALL drop the event and set sticky ovf, unless a pop occurs the same cycle, in which case the push is accepted.
REQ-018 Status register (rs=0) = {nempty, ovf, err, head.rel, head.ext, count[2:0]}; count saturates at 7; head bits 0 when empty.
REQ-019 Data register (rs=1) = head.code, or 8'h00 when empty.
REQ-020 sys_data SHALL update the cycle after sys_adr changes (1-cycle read latency) and be 8'hZZ when not selected.
REQ-021 Access = first cycle an address in the window is presented after a cycle with a different address or no selection; holding the same address SHALL not repeat side effects.
REQ-022 Data-register access SHALL pop the head when non-empty; no pop and no state change when empty.
REQ-023 Status-register access SHALL clear ovf and err after returning their current values.
REQ-024 Simultaneous push and pop on empty FIFO: pop ignored, push accepted.

Reset
REQ-025 RESB low: FIFO empty, pointers 0, FSM IDLE, ovf=err=0, sys_data=8'hZZ, sys_irq=1, access-tracking register cleared.
REQ-026 Reset mid-prefix SHALL discard the pending prefix; first byte after release is decoded from IDLE.

Configuration
REQ-027 KBD_IRQ_EN defined: sys_irq registered, low while FIFO non-empty or ovf set, high one cycle after the FIFO drains and ovf is cleared.
REQ-028 KBD_IRQ_EN undefined: sys_irq constant 1; no IRQ logic synthesized; polling via status only.

Structure
REQ-029 Package kbd_pkg SHALL hold the entry struct, FSM state enum, PS/2 prefix constants (8'hE0, 8'hF0) and the window decode constant.
REQ-030 Storage SHALL be a sub-module kbd_fifo (generic synchronous FIFO, push/pop/full/empty/count, parameter DEPTH); prefix FSM and bus logic stay in kbd_event_fifo.

Verification
REQ-031 Bytes 1C -> status reads 0x81, data read returns 0x1C, next status 0x00.
REQ-032 Bytes E0 F0 74 -> one entry, status 0x99, data 0x74.
REQ-033 Nine plain bytes with DEPTH=8 and no reads -> eight entries kept, ovf=1; status read clears ovf; eight pops return codes 1..8 in order.
REQ-034 F0 with in_error=1, then 1C -> err set, entry {0,0,1C} (not release).
REQ-035 Data address held 3 cycles with two entries queued -> exactly one pop; count drops 2->1.
REQ-036 With KBD_IRQ_EN: push 1C -> sys_irq low next cycle; pop -> sys_irq high; without macro sys_irq stays 1 throughout.
